// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings, datapath widths, the HI/LO payload and a magnitude helper.
package muldiv_pkg;

  localparam int unsigned MULDIV_CYCLES = 32;
  localparam int unsigned XLEN          = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // Two's-complement magnitude when neg is set, passthrough otherwise.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (~x + XLEN'(1)) : x;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between a pipeline front end and the muldiv unit.
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  op_e             op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            div_by_zero;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo, div_by_zero
  );

endinterface

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// A single 64-bit shift register carries both shift-add and restoring divide.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned CYCLES = MULDIV_CYCLES
) (
  input logic      clk,
  input logic      reset,
  muldiv_if.slave  bus
);

  localparam int unsigned   CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   a_r;
  op_e               op_r;
  logic              neg_a;
  logic              neg_b;
  logic              b_zero;

  logic              busy_q;
  logic              done_q;
  logic              dbz_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;

  logic              is_div;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] step;
  hilo_t             fixed;
  logic              start_signed;
  logic              start_neg_a;
  logic              start_neg_b;

  assign is_div       = (op_r == OP_DIV) || (op_r == OP_DIVU);
  assign start_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign start_neg_a  = start_signed & bus.a[XLEN-1];
  assign start_neg_b  = start_signed & bus.b[XLEN-1];

  // One iteration: multiply adds into the upper half and shifts right,
  // divide shifts left and keeps the trial subtraction when it does not borrow.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    step      = acc;
    if (is_div) begin
      if (!div_trial[XLEN]) begin
        step = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        step = {acc[2*XLEN-2:0], 1'b0};
      end
    end else if (acc[0]) begin
      step = {mul_sum, acc[XLEN-1:1]};
    end else begin
      step = {1'b0, acc[2*XLEN-1:1]};
    end
  end

  // Sign correction on the magnitude result; divide-by-zero overrides the
  // iterated value so the remainder is the untouched dividend.
  always_comb begin
    fixed.hi = acc[2*XLEN-1:XLEN];
    fixed.lo = acc[XLEN-1:0];
    if (!is_div) begin
      if (neg_a ^ neg_b) begin
        fixed = hilo_t'(~acc + (2*XLEN)'(1));
      end
    end else if (b_zero) begin
      fixed.hi = a_r;
      fixed.lo = '1;
    end else begin
      if (neg_a ^ neg_b) begin
        fixed.lo = ~acc[XLEN-1:0] + XLEN'(1);
      end
      if (neg_a) begin
        fixed.hi = ~acc[2*XLEN-1:XLEN] + XLEN'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_r    <= '0;
      op_r   <= OP_MULT;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      b_zero <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // busy_q still high here means this is the done-pulse cycle.
          if (busy_q) begin
            busy_q <= 1'b0;
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
            if (bus.start) begin
              op_r   <= bus.op;
              a_r    <= bus.a;
              neg_a  <= start_neg_a;
              neg_b  <= start_neg_b;
              b_zero <= (bus.b == '0);
              acc    <= {{XLEN{1'b0}}, mag(bus.a, start_neg_a)};
              opnd   <= mag(bus.b, start_neg_b);
              cnt    <= '0;
              busy_q <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          acc <= step;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= FIX;
        end
        FIX: begin
          acc   <= fixed;
          state <= DONE;
        end
        DONE: begin
          hi_q   <= acc[2*XLEN-1:XLEN];
          lo_q   <= acc[XLEN-1:0];
          dbz_q  <= is_div & b_zero;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv.sv
// Scoreboard bench for muldiv: expected HI/LO from a 64-bit arithmetic model
// are queued at issue time and popped when the done pulse appears.
module tb_muldiv;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  muldiv_if bus();

  muldiv #(.CYCLES(MULDIV_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  function automatic exp_t model(input op_e op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sbv, q, r;
    logic [63:0] p;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    e.dbz = 1'b0;
    case (op)
      OP_MULT:  begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; end
      OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
        end else if (op == OP_DIV) begin
          q = sa / sbv; r = sa % sbv;
          e.lo = q[31:0]; e.hi = r[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Called at a negedge; start is seen by exactly one rising edge.
  task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b);
    sb.push_back(model(op, a, b));
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (bus.done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd9; bus.b = 32'd9;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hCAFE_F00D;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h dbz=%b want all zero", bus.busy, bus.done, bus.hi, bus.lo, bus.div_by_zero);
    end
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu_max();
    int lat; bit ok; exp_t e;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b want 1", bus.busy); end
    wait_done(lat, ok);
    n_tests++;
    if (!ok || lat != 34) begin n_fail++; $display("FAIL multu_latency: got %0d (seen=%0b) want 34", lat, ok); end
    e = sb.pop_front();
    n_tests++;
    if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001 || bus.hi !== e.hi || bus.lo !== e.lo) begin
      n_fail++;
      $display("FAIL multu_max: got hi=%h lo=%h want hi=fffffffe lo=00000001", bus.hi, bus.lo);
    end
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_done_cycle: got %b want 1", bus.busy); end
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL after_done: got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_mult_div();
    int lat; bit ok; exp_t e;
    op_e         ops[4] = '{OP_MULT, OP_DIV, OP_DIVU, OP_DIV};
    logic [31:0] as[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'd7};
    logic [31:0] bs[4]  = '{32'd7, 32'd2, 32'd7, 32'hFFFF_FFFE};
    logic [31:0] his[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd1};
    logic [31:0] los[4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFD};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(lat, ok);
      e = sb.pop_front();
      n_tests++;
      if (!ok || bus.hi !== his[i] || bus.lo !== los[i] || bus.hi !== e.hi || bus.lo !== e.lo || bus.div_by_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL mult_div[%0d]: got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=0", i, bus.hi, bus.lo, bus.div_by_zero, his[i], los[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    int lat; bit ok; exp_t e;
    issue(OP_DIVU, 32'd5, 32'd0);
    wait_done(lat, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || lat != 34 || bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'd5 || bus.div_by_zero !== 1'b1 || e.dbz !== 1'b1) begin
      n_fail++;
      $display("FAIL divu_by_zero: got lat=%0d hi=%h lo=%h dbz=%b want lat=34 hi=00000005 lo=ffffffff dbz=1", lat, bus.hi, bus.lo, bus.div_by_zero);
    end
    @(negedge clk);
    issue(OP_MULTU, 32'd2, 32'd3);
    wait_done(lat, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || bus.lo !== 32'd6 || bus.hi !== 32'd0 || bus.div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL dbz_clear: got hi=%h lo=%h dbz=%b want hi=0 lo=6 dbz=0", bus.hi, bus.lo, bus.div_by_zero);
    end
    @(negedge clk);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0 || bus.div_by_zero !== 1'b0 || e.lo !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL div_overflow: got hi=%h lo=%h dbz=%b want hi=0 lo=80000000 dbz=0", bus.hi, bus.lo, bus.div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_move();
    int lat; bit ok; exp_t e;
    bus.hi_we = 1'b1; bus.wdata = 32'hA5A5_0001;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h5A5A_0002;
    @(negedge clk);
    bus.lo_we = 1'b0;
    n_tests++;
    if (bus.hi !== 32'hA5A5_0001 || bus.lo !== 32'h5A5A_0002) begin
      n_fail++; $display("FAIL mthi_mtlo: got hi=%h lo=%h want hi=a5a50001 lo=5a5a0002", bus.hi, bus.lo);
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (bus.hi !== 32'hA5A5_0001 || bus.lo !== 32'h5A5A_0002) begin
      n_fail++; $display("FAIL hilo_hold: got hi=%h lo=%h want hi=a5a50001 lo=5a5a0002", bus.hi, bus.lo);
    end
    bus.hi_we = 1'b1; bus.wdata = 32'h1234_5678;
    issue(OP_MULTU, 32'd3, 32'd4);
    bus.hi_we = 1'b0;
    n_tests++;
    if (bus.hi !== 32'h1234_5678 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL write_with_start: got hi=%h busy=%b want hi=12345678 busy=1", bus.hi, bus.busy);
    end
    wait_done(lat, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || bus.hi !== e.hi || bus.lo !== e.lo || bus.lo !== 32'd12) begin
      n_fail++; $display("FAIL start_after_write: got hi=%h lo=%h want hi=%h lo=%h", bus.hi, bus.lo, e.hi, e.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int lat; bit ok; int d0; exp_t e;
    d0 = done_cnt;
    issue(OP_MULTU, 32'h0001_0003, 32'h0000_0105);
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd3;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    wait_done(lat, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || lat != 24 || bus.hi !== e.hi || bus.lo !== e.lo) begin
      n_fail++;
      $display("FAIL busy_ignore_result: got lat=%0d hi=%h lo=%h want lat=24 hi=%h lo=%h", lat, bus.hi, bus.lo, e.hi, e.lo);
    end
    repeat (40) @(negedge clk);
    n_tests++;
    if (done_cnt - d0 != 1 || bus.busy !== 1'b0 || bus.lo !== e.lo) begin
      n_fail++;
      $display("FAIL busy_ignore_single: got done_pulses=%0d busy=%b lo=%h want 1 0 %h", done_cnt - d0, bus.busy, bus.lo, e.lo);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit ok; int d0; exp_t e;
    issue(OP_DIV, 32'hFFFF_FF00, 32'd3);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    e = sb.pop_front();
    d0 = done_cnt;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", bus.busy, bus.done, bus.hi, bus.lo);
    end
    repeat (40) @(negedge clk);
    n_tests++;
    if (done_cnt != d0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_no_done: got done_pulses=%0d hi=%h lo=%h want 0 0 0", done_cnt - d0, bus.hi, bus.lo);
    end
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(lat, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || lat != 34 || bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      n_fail++;
      $display("FAIL restart_after_reset: got lat=%0d hi=%h lo=%h want 34 2 14", lat, bus.hi, bus.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat; bit ok; exp_t e; op_e op; logic [31:0] a, b;
    for (int i = 0; i < 14; i++) begin
      case (i)
        0: begin op = OP_MULT;  a = 32'h8000_0000; b = 32'h8000_0000; end
        1: begin op = OP_DIV;   a = 32'hFFFF_FFF0; b = 32'd0;         end
        2: begin op = OP_DIV;   a = 32'd0;         b = 32'hFFFF_FFFB; end
        3: begin op = OP_DIVU;  a = 32'hFFFF_FFFF; b = 32'd1;         end
        default: begin
          op = op_e'($urandom_range(0, 3));
          a  = $urandom;
          b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : 32'($urandom);
        end
      endcase
      issue(op, a, b);
      wait_done(lat, ok);
      e = sb.pop_front();
      n_tests++;
      if (!ok || lat != 34 || bus.hi !== e.hi || bus.lo !== e.lo || bus.div_by_zero !== e.dbz) begin
        n_fail++;
        $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got lat=%0d hi=%h lo=%h dbz=%b want lat=34 hi=%h lo=%h dbz=%b",
                 i, op, a, b, lat, bus.hi, bus.lo, bus.div_by_zero, e.hi, e.lo, e.dbz);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op = OP_MULT; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    @(negedge clk);
    test_reset();
    test_multu_max();
    test_mult_div();
    test_div_zero();
    test_move();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
